// File: rtl/lc3_control_fsm.sv
// LC-3 control unit: Moore FSM sequencing fetch, decode and execute, with
// parameterised SRAM wait states for memory reads and writes.
module lc3_control_fsm #(
  parameter int MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic       MIO_EN,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  typedef enum logic [4:0] {
    HALTED, S18, S33, S35, S32, S01, S05, S09, S00, S22, S12,
    S04, S21, S06, S07, S25, S27, S23, S16, PAUSE_IR1, PAUSE_IR2
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

  state_t     state, state_n;
  logic [3:0] wait_cnt, wait_cnt_n;
  logic       imm_sel;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= HALTED;
      wait_cnt <= '0;
      imm_sel  <= 1'b0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      // IR[5] is captured at dispatch so SR2MUX stays a function of registers only
      if (state == S32) imm_sel <= IR_5;
    end
  end

  always_comb begin
    state_n    = state;
    wait_cnt_n = '0;
    LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR  = 1'b0; LD_BEN = 1'b0;
    LD_CC  = 1'b0; LD_REG = 1'b0; LD_PC  = 1'b0; LD_LED = 1'b0;
    GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
    PCMUX  = 2'b00; ADDR2MUX = 2'b00; ALUK = 2'b00;
    DRMUX  = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0; ADDR1MUX = 1'b0;
    MIO_EN = 1'b0; Mem_OE = 1'b1; Mem_WE = 1'b1;

    unique case (state)
      HALTED: if (Run) state_n = S18;
      S18: begin
        GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; PCMUX = 2'b00;
        state_n = S33;
      end
      S33, S25: begin
        Mem_OE = 1'b0; MIO_EN = 1'b1; LD_MDR = 1'b1;
        if (wait_cnt == WAIT_LAST) state_n = (state == S33) ? S35 : S27;
        else wait_cnt_n = wait_cnt + 4'd1;
      end
      S35: begin
        GateMDR = 1'b1; LD_IR = 1'b1;
        state_n = S32;
      end
      S32: begin
        LD_BEN = 1'b1;
        unique case (Opcode)
          4'b0001: state_n = S01;
          4'b0101: state_n = S05;
          4'b1001: state_n = S09;
          4'b0000: state_n = S00;
          4'b1100: state_n = S12;
          4'b0100: state_n = S04;
          4'b0110: state_n = S06;
          4'b0111: state_n = S07;
          4'b1101: state_n = PAUSE_IR1;
          default: state_n = S18;
        endcase
      end
      S01, S05, S09: begin
        GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        SR2MUX  = imm_sel;
        ALUK    = (state == S01) ? 2'b00 : (state == S05) ? 2'b01 : 2'b10;
        state_n = S18;
      end
      S00: state_n = BEN ? S22 : S18;
      S22: begin
        ADDR2MUX = 2'b10; PCMUX = 2'b01; LD_PC = 1'b1;
        state_n = S18;
      end
      S12: begin
        ADDR1MUX = 1'b1; PCMUX = 2'b01; LD_PC = 1'b1;
        state_n = S18;
      end
      S04: begin
        GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1;
        state_n = S21;
      end
      S21: begin
        ADDR2MUX = 2'b11; PCMUX = 2'b01; LD_PC = 1'b1;
        state_n = S18;
      end
      S06, S07: begin
        ADDR1MUX = 1'b1; ADDR2MUX = 2'b01; GateMARMUX = 1'b1; LD_MAR = 1'b1;
        state_n = (state == S06) ? S25 : S23;
      end
      S27: begin
        GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        state_n = S18;
      end
      S23: begin
        SR1MUX = 1'b1; ALUK = 2'b11; GateALU = 1'b1; LD_MDR = 1'b1;
        state_n = S16;
      end
      S16: begin
        Mem_WE = 1'b0;
        if (wait_cnt == WAIT_LAST) state_n = S18;
        else wait_cnt_n = wait_cnt + 4'd1;
      end
      PAUSE_IR1: begin
        LD_LED = 1'b1;
        if (Continue) state_n = PAUSE_IR2;
      end
      PAUSE_IR2: if (!Continue) state_n = S18;
      default: state_n = HALTED;
    endcase
  end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Directed bench for lc3_control_fsm: compares every control output, packed
// into one word, against hand-derived per-state values cycle by cycle.
module tb_lc3_control_fsm;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1, Run = 1'b1, Continue = 1'b0;
  logic [3:0] Opcode = 4'b0000;
  logic       IR_5 = 1'b0, BEN = 1'b0;
  logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, Mem_OE, Mem_WE;

  int checks = 0;
  int errors = 0;

  lc3_control_fsm #(.MEM_WAIT(2)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
    .Opcode(Opcode), .IR_5(IR_5), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
    .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
    .MIO_EN(MIO_EN), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
  );

  always #5 Clk = ~Clk;

  // ld: MAR MDR IR BEN CC REG PC LED ; gate: PC MDR ALU MARMUX
  function automatic logic [24:0] mk(input logic [7:0] ld, input logic [3:0] gate,
                                     input logic [1:0] pcm, input logic [1:0] a2m,
                                     input logic [1:0] aluk, input logic drm,
                                     input logic sr1m, input logic sr2m, input logic a1m,
                                     input logic mio, input logic oe, input logic we);
    return {ld, gate, pcm, a2m, aluk, drm, sr1m, sr2m, a1m, mio, oe, we};
  endfunction

  localparam logic [24:0] W_HALT  = mk(8'h00, 4'h0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1);
  localparam logic [24:0] W_S18   = mk(8'h82, 4'h8, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1);
  localparam logic [24:0] W_RD    = mk(8'h40, 4'h0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 1);
  localparam logic [24:0] W_S35   = mk(8'h20, 4'h4, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1);
  localparam logic [24:0] W_S32   = mk(8'h10, 4'h0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1);
  localparam logic [24:0] W_ADDI  = mk(8'h0C, 4'h2, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0, 1, 1);
  localparam logic [24:0] W_ANDR  = mk(8'h0C, 4'h2, 2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 0, 1, 1);
  localparam logic [24:0] W_NOT   = mk(8'h0C, 4'h2, 2'b00, 2'b00, 2'b10, 0, 0, 0, 0, 0, 1, 1);
  localparam logic [24:0] W_S22   = mk(8'h02, 4'h0, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 0, 1, 1);
  localparam logic [24:0] W_S12   = mk(8'h02, 4'h0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 1, 0, 1, 1);
  localparam logic [24:0] W_S04   = mk(8'h04, 4'h8, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 1, 1);
  localparam logic [24:0] W_S21   = mk(8'h02, 4'h0, 2'b01, 2'b11, 2'b00, 0, 0, 0, 0, 0, 1, 1);
  localparam logic [24:0] W_EA    = mk(8'h80, 4'h1, 2'b00, 2'b01, 2'b00, 0, 0, 0, 1, 0, 1, 1);
  localparam logic [24:0] W_S27   = mk(8'h0C, 4'h4, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1);
  localparam logic [24:0] W_S23   = mk(8'h40, 4'h2, 2'b00, 2'b00, 2'b11, 0, 1, 0, 0, 0, 1, 1);
  localparam logic [24:0] W_S16   = mk(8'h00, 4'h0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0);
  localparam logic [24:0] W_P1    = mk(8'h01, 4'h0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1);

  task automatic step(output logic [24:0] obs);
    @(posedge Clk);
    #1;
    obs = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
           GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, ADDR2MUX, ALUK,
           DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, Mem_OE, Mem_WE};
  endtask

  task automatic test_reset;
    logic [24:0] obs;
    logic [24:0] exp_q[$];
    Reset = 1'b1; Run = 1'b1;
    exp_q = '{W_HALT, W_HALT};
    foreach (exp_q[i]) begin
      step(obs);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++; $display("FAIL reset cyc %0d got %h exp %h", i, obs, exp_q[i]);
      end
    end
    Reset = 1'b0; Opcode = 4'b0001; IR_5 = 1'b1;
    step(obs);
    checks++;
    if (obs !== W_S18) begin
      errors++; $display("FAIL reset_release got %h exp %h", obs, W_S18);
    end
  endtask

  task automatic test_alu;
    logic [24:0] obs;
    logic [24:0] exp_q[$];
    exp_q = '{W_RD, W_RD, W_S35, W_S32, W_ADDI, W_S18};
    foreach (exp_q[i]) begin
      step(obs);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++; $display("FAIL add_imm cyc %0d got %h exp %h", i, obs, exp_q[i]);
      end
    end
    Opcode = 4'b0101; IR_5 = 1'b0;
    exp_q = '{W_RD, W_RD, W_S35, W_S32, W_ANDR, W_S18};
    foreach (exp_q[i]) begin
      step(obs);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++; $display("FAIL and_reg cyc %0d got %h exp %h", i, obs, exp_q[i]);
      end
    end
    Opcode = 4'b1001;
    exp_q = '{W_RD, W_RD, W_S35, W_S32, W_NOT, W_S18};
    foreach (exp_q[i]) begin
      step(obs);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++; $display("FAIL not cyc %0d got %h exp %h", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_branch;
    logic [24:0] obs;
    logic [24:0] exp_q[$];
    Opcode = 4'b0000; BEN = 1'b0;
    exp_q = '{W_RD, W_RD, W_S35, W_S32, W_HALT, W_S18};
    foreach (exp_q[i]) begin
      step(obs);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++; $display("FAIL br_not_taken cyc %0d got %h exp %h", i, obs, exp_q[i]);
      end
    end
    BEN = 1'b1;
    exp_q = '{W_RD, W_RD, W_S35, W_S32, W_HALT, W_S22, W_S18};
    foreach (exp_q[i]) begin
      step(obs);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++; $display("FAIL br_taken cyc %0d got %h exp %h", i, obs, exp_q[i]);
      end
    end
    BEN = 1'b0;
  endtask

  task automatic test_jumps;
    logic [24:0] obs;
    logic [24:0] exp_q[$];
    Opcode = 4'b1100;
    exp_q = '{W_RD, W_RD, W_S35, W_S32, W_S12, W_S18};
    foreach (exp_q[i]) begin
      step(obs);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++; $display("FAIL jmp cyc %0d got %h exp %h", i, obs, exp_q[i]);
      end
    end
    Opcode = 4'b0100;
    exp_q = '{W_RD, W_RD, W_S35, W_S32, W_S04, W_S21, W_S18};
    foreach (exp_q[i]) begin
      step(obs);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++; $display("FAIL jsr cyc %0d got %h exp %h", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_mem;
    logic [24:0] obs;
    logic [24:0] exp_q[$];
    Opcode = 4'b0110;
    exp_q = '{W_RD, W_RD, W_S35, W_S32, W_EA, W_RD, W_RD, W_S27, W_S18};
    foreach (exp_q[i]) begin
      step(obs);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++; $display("FAIL ldr cyc %0d got %h exp %h", i, obs, exp_q[i]);
      end
    end
    Opcode = 4'b0111;
    exp_q = '{W_RD, W_RD, W_S35, W_S32, W_EA, W_S23, W_S16, W_S16, W_S18};
    foreach (exp_q[i]) begin
      step(obs);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++; $display("FAIL str cyc %0d got %h exp %h", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_nop;
    logic [24:0] obs;
    logic [24:0] exp_q[$];
    Opcode = 4'b1111;
    exp_q = '{W_RD, W_RD, W_S35, W_S32, W_S18};
    foreach (exp_q[i]) begin
      step(obs);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++; $display("FAIL nop cyc %0d got %h exp %h", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_pause;
    logic [24:0] obs;
    logic [24:0] exp_q[$];
    Opcode = 4'b1101; Continue = 1'b0;
    exp_q = '{W_RD, W_RD, W_S35, W_S32, W_P1, W_P1, W_P1, W_P1, W_P1,
              W_P1, W_P1, W_P1, W_P1, W_P1, W_P1};
    foreach (exp_q[i]) begin
      step(obs);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++; $display("FAIL pause1 cyc %0d got %h exp %h", i, obs, exp_q[i]);
      end
    end
    Continue = 1'b1;
    exp_q = '{W_HALT, W_HALT, W_HALT};
    foreach (exp_q[i]) begin
      step(obs);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++; $display("FAIL pause2 cyc %0d got %h exp %h", i, obs, exp_q[i]);
      end
    end
    Continue = 1'b0;
    step(obs);
    checks++;
    if (obs !== W_S18) begin
      errors++; $display("FAIL pause_exit got %h exp %h", obs, W_S18);
    end
  endtask

  task automatic test_reset_mid_wait;
    logic [24:0] obs;
    logic [24:0] exp_q[$];
    Opcode = 4'b0110; Run = 1'b0;
    exp_q = '{W_RD, W_RD, W_S35, W_S32, W_EA, W_RD, W_RD};
    foreach (exp_q[i]) begin
      step(obs);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++; $display("FAIL ldr_pre_reset cyc %0d got %h exp %h", i, obs, exp_q[i]);
      end
    end
    Reset = 1'b1;
    step(obs);
    Reset = 1'b0;
    checks++;
    if (obs !== W_HALT) begin
      errors++; $display("FAIL reset_mid_wait got %h exp %h", obs, W_HALT);
    end
    exp_q = '{W_HALT, W_HALT, W_HALT, W_HALT, W_HALT};
    foreach (exp_q[i]) begin
      step(obs);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++; $display("FAIL halted_hold cyc %0d got %h exp %h", i, obs, exp_q[i]);
      end
    end
    Run = 1'b1;
    step(obs);
    Run = 1'b0;
    checks++;
    if (obs !== W_S18) begin
      errors++; $display("FAIL restart got %h exp %h", obs, W_S18);
    end
    exp_q = '{W_RD, W_RD, W_S35};
    foreach (exp_q[i]) begin
      step(obs);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++; $display("FAIL restart_read cyc %0d got %h exp %h", i, obs, exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_branch;
    test_jumps;
    test_mem;
    test_nop;
    test_pause;
    test_reset_mid_wait;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
